// File: rtl/sigmoid_inverse.sv
// rtl/sigmoid_inverse.sv - inverse rational sigmoid x = y/(1-|y|), y = 2s-1; SIGINV_CLAMP_EN enables |x| saturation
package sigmoid_inverse_pkg;
    // round {hidden, 23 frac, guard, sticky} to binary32; returns {inexact, bits}; callers only produce normal results
    function automatic logic [32:0] fp_round(input logic sg, input logic [7:0] be, input logic [25:0] sig,
                                             input logic [2:0] rm);
        logic        inc;
        logic        gs;
        logic [24:0] m;
        gs = sig[1] | sig[0];
        case (rm)
            3'd1:    inc = 1'b0;
            3'd2:    inc = sg & gs;
            3'd3:    inc = ~sg & gs;
            3'd4:    inc = sig[1];
            default: inc = sig[1] & (sig[0] | sig[2]);
        endcase
        m = {1'b0, sig[25:2]} + {24'd0, inc};
        return {gs, sg, be + {7'd0, m[24]}, (m[24] ? m[23:1] : m[22:0])};
    endfunction

    // normalize a nonzero magnitude in units of 2^-50 and round it to binary32
    function automatic logic [32:0] norm_round(input logic sg, input logic [51:0] m, input logic [2:0] rm);
        logic [5:0]  p;
        logic [51:0] n;
        p = 6'd0;
        for (int i = 0; i < 52; i++) if (m[i]) p = 6'(i);
        n = m << (6'd51 - p);
        return fp_round(sg, {2'd0, p} + 8'd77, {n[51:27], |n[26:0]}, rm);
    endfunction
endpackage

module sigmoid_inverse_div
    import sigmoid_inverse_pkg::*;
(
    input  logic        clk,
    input  logic        rst_l,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        cancel,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  round_mode,
    output logic        out_valid,
    output logic [31:0] out,
    output logic [4:0]  out_exc
);
    logic        busy, dz, sgn;
    logic [4:0]  cnt;
    logic [24:0] rem;
    logic [23:0] mb;
    logic [26:0] q;
    logic [7:0]  ebase, be;
    logic [2:0]  rm;
    logic [25:0] sig;
    logic [32:0] rounded;

    assign in_ready = ~busy;

    // quotient lands in [1,2) or [0.5,1): pick the mantissa window and exponent to match
    always_comb begin
        sig     = q[26] ? {q[26:2], |{q[1:0], rem}} : {q[25:1], |{q[0], rem}};
        be      = ebase - {7'd0, ~q[26]};
        rounded = fp_round(sgn, be, sig, rm);
    end

    // restoring mantissa division, one quotient bit per cycle, then a single-cycle result pulse
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            busy      <= 1'b0;
            dz        <= 1'b0;
            sgn       <= 1'b0;
            cnt       <= 5'd0;
            rem       <= 25'd0;
            mb        <= 24'd0;
            q         <= 27'd0;
            ebase     <= 8'd0;
            rm        <= 3'd0;
            out_valid <= 1'b0;
            out       <= 32'd0;
            out_exc   <= 5'd0;
        end else begin
            out_valid <= 1'b0;
            if (cancel) begin
                busy <= 1'b0;
            end else if (!busy) begin
                if (in_valid) begin
                    busy  <= 1'b1;
                    sgn   <= a[31] ^ b[31];
                    dz    <= (b[30:0] == 31'd0);
                    cnt   <= (b[30:0] == 31'd0) ? 5'd0 : 5'd27;
                    rem   <= {2'b01, a[22:0]};
                    mb    <= {1'b1, b[22:0]};
                    q     <= 27'd0;
                    ebase <= a[30:23] - b[30:23] + 8'd127;
                    rm    <= round_mode;
                end
            end else if (cnt != 5'd0) begin
                if (rem >= {1'b0, mb}) begin
                    rem <= (rem - {1'b0, mb}) << 1;
                    q   <= {q[25:0], 1'b1};
                end else begin
                    rem <= rem << 1;
                    q   <= {q[25:0], 1'b0};
                end
                cnt <= cnt - 5'd1;
            end else begin
                busy      <= 1'b0;
                out_valid <= 1'b1;
                if (dz) begin
                    out     <= {sgn, 8'hff, 23'd0};
                    out_exc <= 5'b01000;
                end else begin
                    out     <= rounded[31:0];
                    out_exc <= {4'd0, rounded[32]};
                end
            end
        end
    end
endmodule

module sigmoid_inverse
    import sigmoid_inverse_pkg::*;
#(
    parameter int          exp_width  = 8,
    parameter int          mant_width = 24,
    parameter logic [31:0] CLAMP_MAG  = 32'h41000000
) (
    input  logic                            clk,
    input  logic                            rst_l,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [exp_width+mant_width-1:0] in_s,
    input  logic [2:0]                      round_mode,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [exp_width+mant_width-1:0] out_x,
    output logic [4:0]                      out_exc
);
`ifdef SIGINV_CLAMP_EN
    localparam bit CLAMP_ON = 1'b1;
`else
    localparam bit CLAMP_ON = 1'b0;
`endif
    localparam logic [51:0] ONE50 = 52'h4000000000000;
    localparam logic [48:0] ONE48 = 49'h1000000000000;

    typedef enum logic [2:0] {IDLE, PREP, DIV_REQ, DIV_WAIT, DONE} state_t;
    state_t state, next_state;

    logic [30:0]  s_r;
    logic [2:0]   rm_r;
    logic [31:0]  y_r, d_r;
    logic [4:0]   exc_r;
    logic         is_nan, is_hi, is_lo, is_half, special;
    logic         div_in_valid, div_in_ready, div_out_valid, big;
    logic [31:0]  div_out;
    logic [4:0]   div_exc;
    logic [7:0]   ee;
    logic [23:0]  ms;
    logic [6:0]   rsh;
    logic [74:0]  w;
    logic [50:0]  v;
    logic         st, y_neg;
    logic [51:0]  v2, ym, dm;
    logic [48:0]  yf, diff;
    logic [32:0]  y_rnd, d_rnd;

    assign is_nan  = (&in_s[30:23]) & (|in_s[22:0]);
    assign is_hi   = ~in_s[31] & (in_s[30:0] >= 31'h3f800000);
    assign is_lo   = in_s[31] | (in_s[30:0] == 31'd0);
    assign is_half = (in_s == 32'h3f000000);
    assign special = is_nan | is_hi | is_lo | is_half;
    assign big     = div_out[30:0] > CLAMP_MAG[30:0];

    // y = 2s-1 on a wide fixed-point grid with a sticky LSB, then d = 1-|y| which is always exact
    always_comb begin
        ee  = (s_r[30:23] == 8'd0) ? 8'd1 : s_r[30:23];
        ms  = {s_r[30:23] != 8'd0, s_r[22:0]};
        rsh = (ee < 8'd49) ? 7'd51 : 7'(8'd100 - ee);
        w   = 75'd0;
        if (ee >= 8'd100) begin
            v  = 51'(ms) << (ee - 8'd100);
            st = 1'b0;
        end else begin
            w  = {ms, 51'd0} >> rsh;
            v  = {27'd0, w[74:51]};
            st = |w[50:0];
        end
        v2    = {v, st};
        y_neg = v2 < ONE50;
        ym    = y_neg ? ONE50 - v2 : v2 - ONE50;
        y_rnd = norm_round(y_neg, ym, rm_r);
        yf    = 49'({1'b1, y_rnd[22:0]}) << (y_rnd[30:23] - 8'd102);
        diff  = ONE48 - yf;
        dm    = {1'b0, diff, 2'b00};
        d_rnd = norm_round(1'b0, dm, rm_r);
    end

    // state register
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) state <= IDLE;
        else        state <= next_state;
    end

    // next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (in_valid) next_state = special ? DONE : PREP;
            PREP:     next_state = DIV_REQ;
            DIV_REQ:  if (div_in_ready) next_state = DIV_WAIT;
            DIV_WAIT: if (div_out_valid) next_state = DONE;
            DONE:     if (out_ready) next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // handshake outputs decoded from state
    always_comb begin
        in_ready     = (state == IDLE);
        out_valid    = (state == DONE);
        div_in_valid = (state == DIV_REQ);
    end

    // operand capture, special-case results, prep registers and final result capture
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            s_r     <= 31'd0;
            rm_r    <= 3'd0;
            y_r     <= 32'd0;
            d_r     <= 32'd0;
            exc_r   <= 5'd0;
            out_x   <= 32'd0;
            out_exc <= 5'd0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    s_r  <= in_s[30:0];
                    rm_r <= round_mode;
                    if (is_nan) begin
                        out_x   <= 32'h7fc00000;
                        out_exc <= 5'b10000;
                    end else if (is_hi) begin
                        out_x   <= CLAMP_ON ? CLAMP_MAG : 32'h7f800000;
                        out_exc <= CLAMP_ON ? 5'b00100 : 5'b01000;
                    end else if (is_lo) begin
                        out_x   <= CLAMP_ON ? {1'b1, CLAMP_MAG[30:0]} : 32'hff800000;
                        out_exc <= CLAMP_ON ? 5'b00100 : 5'b01000;
                    end else if (is_half) begin
                        out_x   <= 32'd0;
                        out_exc <= 5'd0;
                    end
                end
                PREP: begin
                    y_r   <= y_rnd[31:0];
                    d_r   <= (diff == 49'd0) ? 32'd0 : d_rnd[31:0];
                    exc_r <= {4'd0, y_rnd[32] | d_rnd[32]};
                end
                DIV_WAIT: if (div_out_valid) begin
                    if (CLAMP_ON && big) begin
                        out_x   <= {div_out[31], CLAMP_MAG[30:0]};
                        out_exc <= exc_r | div_exc | 5'b00100;
                    end else begin
                        out_x   <= div_out;
                        out_exc <= exc_r | div_exc;
                    end
                end
                default: ;
            endcase
        end
    end

    sigmoid_inverse_div u_div (
        .clk        (clk),
        .rst_l      (rst_l),
        .in_valid   (div_in_valid),
        .in_ready   (div_in_ready),
        .cancel     (1'b0),
        .a          (y_r),
        .b          (d_r),
        .round_mode (rm_r),
        .out_valid  (div_out_valid),
        .out        (div_out),
        .out_exc    (div_exc)
    );
endmodule

// File: tb/tb_sigmoid_inverse.sv
// tb/tb_sigmoid_inverse.sv - directed scoreboard bench for sigmoid_inverse
module tb_sigmoid_inverse;
    logic        clk = 1'b0;
    logic        rst_l = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_s = 32'd0;
    logic [2:0]  round_mode = 3'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_x;
    logic [4:0]  out_exc;

    int n_vec = 0;
    int n_bad = 0;
    int div_reqs = 0;
    int req0;
    int seen;

    logic [31:0] exp_x_q[$];
    logic [4:0]  exp_e_q[$];

`ifdef SIGINV_CLAMP_EN
    localparam logic [31:0] X_HI = 32'h41000000, X_LO = 32'hc1000000;
    localparam logic [4:0]  E_HI = 5'b00100,     E_LO = 5'b00100;
    localparam logic [31:0] X_TNE = 32'hc1000000, X_TRZ = 32'hc1000000, X_N1 = 32'h41000000;
    localparam logic [4:0]  E_TNE = 5'b01101,     E_TRZ = 5'b00101,     E_N1 = 5'b00100;
`else
    localparam logic [31:0] X_HI = 32'h7f800000, X_LO = 32'hff800000;
    localparam logic [4:0]  E_HI = 5'b01000,     E_LO = 5'b01000;
    localparam logic [31:0] X_TNE = 32'hff800000, X_TRZ = 32'hcb7fffff, X_N1 = 32'h4afffffe;
    localparam logic [4:0]  E_TNE = 5'b01001,     E_TRZ = 5'b00001,     E_N1 = 5'b00000;
`endif

    always #5 clk = ~clk;

    sigmoid_inverse dut (
        .clk        (clk),
        .rst_l      (rst_l),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_s       (in_s),
        .round_mode (round_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_x      (out_x),
        .out_exc    (out_exc)
    );

    always @(posedge clk) if (dut.div_in_valid) div_reqs <= div_reqs + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic apply(input string tag, input logic [31:0] s, input logic [2:0] rm,
                         input logic [31:0] ex, input logic [4:0] ee, input int hold, input bit special);
        int n;
        exp_x_q.push_back(ex);
        exp_e_q.push_back(ee);
        @(negedge clk);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        in_valid   = 1'b1;
        in_s       = s;
        round_mode = rm;
        out_ready  = (hold == 0);
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        in_s       = $urandom;
        round_mode = 3'($urandom_range(0, 4));
        n = 1;
        while (!out_valid && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
        if (special) check({tag, "_latency"}, n, 32'd1);
        check({tag, "_x"}, out_x, exp_x_q.pop_front());
        check({tag, "_exc"}, {27'd0, out_exc}, {27'd0, exp_e_q.pop_front()});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, "_hold_x"}, out_x, ex);
            check({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
            check({tag, "_hold_in_ready"}, {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_single_pulse"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_idle_again"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_x", out_x, 32'd0);
        check("rst_out_exc", {27'd0, out_exc}, 32'd0);
        check("rst_div_valid", {31'd0, dut.div_in_valid}, 32'd0);
        @(negedge clk);
        rst_l = 1'b1;

        apply("s0p75", 32'h3f400000, 3'd0, 32'h3f800000, 5'b00000, 0, 1'b0);
        apply("s0p25", 32'h3e800000, 3'd0, 32'hbf800000, 5'b00000, 0, 1'b0);
        apply("s0p875_hold", 32'h3f600000, 3'd0, 32'h40400000, 5'b00000, 5, 1'b0);
        req0 = div_reqs;
        apply("half", 32'h3f000000, 3'd0, 32'h00000000, 5'b00000, 0, 1'b1);
        check("half_no_div_req", div_reqs - req0, 32'd0);
        apply("one", 32'h3f800000, 3'd0, X_HI, E_HI, 0, 1'b1);
        apply("pinf", 32'h7f800000, 3'd0, X_HI, E_HI, 0, 1'b1);
        apply("two", 32'h40000000, 3'd0, X_HI, E_HI, 0, 1'b1);
        apply("zero", 32'h00000000, 3'd0, X_LO, E_LO, 0, 1'b1);
        apply("negzero", 32'h80000000, 3'd0, X_LO, E_LO, 0, 1'b1);
        apply("neg", 32'hbf800000, 3'd0, X_LO, E_LO, 2, 1'b1);
        apply("nan", 32'h7fc00001, 3'd0, 32'h7fc00000, 5'b10000, 0, 1'b1);
        apply("negnan", 32'hffc00000, 3'd0, 32'h7fc00000, 5'b10000, 0, 1'b1);
        apply("third_rne", 32'h3f200000, 3'd0, 32'h3eaaaaab, 5'b00001, 0, 1'b0);
        apply("third_rtz", 32'h3f200000, 3'd1, 32'h3eaaaaaa, 5'b00001, 0, 1'b0);
        apply("mthird_rdn", 32'h3ec00000, 3'd2, 32'hbeaaaaab, 5'b00001, 0, 1'b0);
        apply("mthird_rup", 32'h3ec00000, 3'd3, 32'hbeaaaaaa, 5'b00001, 0, 1'b0);
        apply("tiny_rne", 32'h00000001, 3'd0, X_TNE, E_TNE, 0, 1'b0);
        apply("tiny_rtz", 32'h00000001, 3'd1, X_TRZ, E_TRZ, 0, 1'b0);
        apply("near_one", 32'h3f7fffff, 3'd0, X_N1, E_N1, 0, 1'b0);
        apply("s1_16", 32'h3d800000, 3'd0, 32'hc0e00000, 5'b00000, 0, 1'b0);

        @(negedge clk);
        in_valid   = 1'b1;
        in_s       = 32'h3f600000;
        round_mode = 3'd0;
        out_ready  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("abort_busy", {31'd0, in_ready}, 32'd0);
        rst_l = 1'b0;
        #3;
        check("abort_rst_valid", {31'd0, out_valid}, 32'd0);
        check("abort_rst_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_l = 1'b1;
        seen = 0;
        repeat (50) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("abort_no_output", seen, 32'd0);
        apply("after_abort", 32'h3f400000, 3'd0, 32'h3f800000, 5'b00000, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
